// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and
// the width helper for the stretch/stagger counter.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    STRETCH   = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  // Wide enough to hold the larger of the two terminal counts.
  function automatic int cnt_width(input int stretch_cycles, input int stage_gap);
    int m;
    m = (stretch_cycles > stage_gap) ? stretch_cycles : stage_gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop single-bit synchroniser with asynchronous reset to a chosen
// level; used for both the reset release and the lock flag.
module sync_bit #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain_q;
  logic [DEPTH-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[DEPTH-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {DEPTH{RST_VAL}};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[DEPTH-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / lock-loss reset sequencer: synchronised release, a lock-gated
// stretch, then per-domain resets released one by one in index order.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int NUM_OUT        = 4,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGE_GAP      = 8
) (
  input  logic               clk,
  input  logic               async_rst_n_in,
  input  logic               lock_in,
  input  logic               sw_reset_req,
  output logic [NUM_OUT-1:0] reset_out,
  output logic               done
);

  localparam int             CW           = cnt_width(STRETCH_CYCLES, STAGE_GAP);
  localparam logic [CW-1:0]  STRETCH_LAST = CW'(STRETCH_CYCLES);
  localparam logic [CW-1:0]  GAP_LAST     = CW'(STAGE_GAP);

  logic rst_sync_n;
  logic lock_sync;

  // Reset synchroniser shifts in ones, so its output stays low until the
  // release has propagated through every stage.
  sync_bit #(
    .DEPTH   (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_rst_sync (
    .clk   (clk),
    .rst_n (async_rst_n_in),
    .d     (1'b1),
    .q     (rst_sync_n)
  );

  sync_bit #(
    .DEPTH   (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (async_rst_n_in),
    .d     (lock_in),
    .q     (lock_sync)
  );

  seq_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [NUM_OUT-1:0] reset_out_q, reset_out_d, reset_out_shift;
  logic               done_q, done_d;
  logic               step_hit;
  logic               restart;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    reset_out_d     = reset_out_q;
    done_d          = done_q;
    step_hit        = 1'b0;
    restart         = 1'b0;
    cnt_inc         = cnt_q + 1'b1;
    // Shifting a zero in from bit 0 releases exactly the next domain and
    // makes out-of-order release impossible by construction.
    reset_out_shift = reset_out_q << 1;

    case (state_q)
      SYNC_WAIT: begin
        cnt_d = '0;
        if (rst_sync_n) begin
          state_d = STRETCH;
        end
      end
      STRETCH: begin
        if (lock_sync) begin
          cnt_d    = cnt_inc;
          step_hit = (cnt_inc == STRETCH_LAST);
        end else begin
          cnt_d = '0;
        end
      end
      RELEASE: begin
        if (lock_sync) begin
          cnt_d    = cnt_inc;
          step_hit = (cnt_inc == GAP_LAST);
        end else begin
          restart = 1'b1;
        end
      end
      RUN: begin
        cnt_d   = '0;
        restart = !lock_sync || sw_reset_req;
      end
      default: begin
        state_d = SYNC_WAIT;
      end
    endcase

    if (step_hit) begin
      cnt_d       = '0;
      reset_out_d = reset_out_shift;
      if (reset_out_shift == '0) begin
        done_d  = 1'b1;
        state_d = RUN;
      end else begin
        state_d = RELEASE;
      end
    end

    if (restart) begin
      cnt_d       = '0;
      reset_out_d = '1;
      done_d      = 1'b0;
      state_d     = STRETCH;
    end
  end

  always_ff @(posedge clk or negedge async_rst_n_in) begin
    if (!async_rst_n_in) begin
      state_q     <= SYNC_WAIT;
      cnt_q       <= '0;
      reset_out_q <= '1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reset_out_q <= reset_out_d;
      done_q      <= done_d;
    end
  end

  assign reset_out = reset_out_q;
  assign done      = done_q;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchroniser depth for the reset release and for lock_in; legal values are 2 and above.
REQ-002 Parameter NUM_OUT, default 4: number of sequenced reset outputs; legal values are 1 and above.
REQ-003 Parameter STRETCH_CYCLES, default 16: cycles from synchronised release (with lock) to the release of reset_out[0]; legal values are 1 and above.
REQ-004 Parameter STAGE_GAP, default 8: cycles between successive output releases; legal values are 1 and above; unused when NUM_OUT is 1.
REQ-005 clk  input  1  sole clock; all logic is clocked on its rising edge.
REQ-006 async_rst_n_in  input  1  asynchronous, active-low reset; assertion takes effect without a clock, release is synchronised internally.
REQ-007 lock_in  input  1  asynchronous PLL/source-ready flag, active-high; synchronised internally.
REQ-008 sw_reset_req  input  1  synchronous single-cycle software reset request, active-high.
REQ-009 reset_out  output  NUM_OUT  per-domain reset, active-high; bit 0 is released first.
REQ-010 done  output  1  high when all reset_out bits are released.

Function
REQ-011 FSM states: SYNC_WAIT, STRETCH, RELEASE, RUN.
REQ-012 SYNC_WAIT: after reset release, wait until the SYNC_STAGES-deep chain outputs deasserted (SYNC_STAGES rising edges), then go to STRETCH.
REQ-013 STRETCH: cycle counter held at 0 while synchronised lock is low; increments while lock is high.
REQ-014 STRETCH exit: reset_out[0] falls on the edge where the counter reaches STRETCH_CYCLES; then go to RELEASE with the counter cleared.
REQ-015 RELEASE: reset_out[k] falls exactly k*STAGE_GAP cycles after reset_out[0]; released bits stay low; bits never release out of order.
REQ-016 On the edge releasing reset_out[NUM_OUT-1], done rises and the FSM enters RUN; NUM_OUT=1 goes directly from STRETCH to RUN.
REQ-017 RUN: outputs hold at reset_out all zero and done=1.
REQ-018 Synchronised lock low in RELEASE or RUN: next edge sets all reset_out high and done low, clears the counter, and enters STRETCH.
REQ-019 sw_reset_req in RUN: same response as REQ-018.
REQ-020 sw_reset_req in SYNC_WAIT, STRETCH or RELEASE is ignored.
REQ-021 sw_reset_req and loss of lock in the same cycle: single restart, identical to REQ-018.
REQ-022 Counter width is clog2(max(STRETCH_CYCLES, STAGE_GAP)+1); the counter never wraps; it saturates or clears per state.
REQ-023 reset_out bits only ever rise together (restart or reset) and fall individually in index order.

Reset
REQ-024 async_rst_n_in low immediately (no clock) forces reset_out to all ones, done=0, FSM=SYNC_WAIT, counter=0, and all synchroniser flops to their asserted state.
REQ-025 Assertion mid-sequence (any state) behaves as REQ-024; the sequence restarts from SYNC_WAIT after release.
REQ-026 The lock synchroniser resets to 0 (not locked).

Structure
REQ-027 State encodings and the counter-width function live in shared package reset_seq_pkg.
REQ-028 Sub-module sync_bit (parametrised depth, reset value) is instantiated once for the reset release and once for lock_in.
REQ-029 Outputs are registered directly from flops; there is no combinational path from any input to reset_out or done except the asynchronous reset.

Verification (defaults; edge 0 = first rising edge after async_rst_n_in rises; lock_in high and settled)
REQ-030 Power-on release: reset_out[0..3] fall at edges 18/26/34/42, done rises at edge 42, and no other output change occurs.
REQ-031 lock_in held low for 100 cycles after release: reset_out stays all ones; once lock_in goes high, reset_out[0] falls 2+16 edges later.
REQ-032 sw_reset_req pulse in RUN: next edge gives reset_out=4'b1111 and done=0; reset_out[0] falls 16 edges later and the 8-cycle stagger repeats.
REQ-033 lock_in drops between the reset_out[1] and reset_out[2] releases: all outputs are high within 3 edges (2 sync + 1) and the sequence restarts after lock returns; an sw_reset_req pulse during RELEASE has no effect.
REQ-034 async_rst_n_in pulsed low for 3 ns between edges during RELEASE: outputs are asserted immediately, without a clock, and the full 18/26/34/42 timing repeats.
REQ-035 Parameter sweep of NUM_OUT=1, SYNC_STAGES=3, STRETCH_CYCLES=1, STAGE_GAP=1: the release edge equals SYNC_STAGES+STRETCH_CYCLES (4), with done on the same edge.
